// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters.
// One DATA_W-bit transfer per grant, with a watchdog abort on a missing reply.
module spi_txn_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic                      busy,
   output logic                      spi_send_en,
   output logic [DATA_W-1:0]         spi_send_data,
   input  logic [DATA_W-1:0]         spi_rx_data,
   input  logic                      spi_rx_valid
);

   localparam int unsigned NR = NUM_REQ;
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  cand;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_found;
   logic [DATA_W-1:0] pick_data;
   logic [TMR_W-1:0]  timer;

   // Round-robin scan starting at rr_ptr; first set request wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_data  = '0;
      cand       = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         cand = IDX_W'((32'(rr_ptr) + i) % NR);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
      for (int unsigned i = 0; i < NR; i++) begin
         if (32'(pick_idx) == i) pick_data = req_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      busy        = 1'b1;
      spi_send_en = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (pick_found) state_nxt = S_LAUNCH;
         end
         S_LAUNCH: begin
            spi_send_en = 1'b1;
            state_nxt   = S_WAIT;
         end
         S_WAIT: begin
            if (spi_rx_valid || timer == TMR_LAST) state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      gnt       = '0;
      rsp_valid = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (32'(idx) == i) begin
            gnt[i]       = (state != S_IDLE);
            rsp_valid[i] = (state == S_DONE);
         end
      end
   end

   // A reply arriving on the terminal timer cycle takes priority over the abort.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr        <= '0;
         idx           <= '0;
         timer         <= '0;
         spi_send_data <= '0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  idx           <= pick_idx;
                  spi_send_data <= pick_data;
               end
            end
            S_LAUNCH: timer <= '0;
            S_WAIT: begin
               if (spi_rx_valid) begin
                  rsp_data <= spi_rx_data;
                  rsp_err  <= 1'b0;
               end else if (timer == TMR_LAST) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DONE: rr_ptr <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter; the bench plays the spi_master reply side.
module tb_spi_txn_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NR-1:0] req = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0] gnt;
   logic [NR-1:0] rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          busy;
   logic          spi_send_en;
   logic [DW-1:0] spi_send_data;
   logic [DW-1:0] spi_rx_data = '0;
   logic          spi_rx_valid = 1'b0;

   int errors = 0;
   int checks = 0;

   spi_txn_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_data      (req_data),
      .gnt           (gnt),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .busy          (busy),
      .spi_send_en   (spi_send_en),
      .spi_send_data (spi_send_data),
      .spi_rx_data   (spi_rx_data),
      .spi_rx_valid  (spi_rx_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_launch(input string tag);
      int n = 0;
      while (!spi_send_en && n < 20) begin
         step();
         n++;
      end
      check({tag, "_launch"}, 32'(spi_send_en), 1);
   endtask

   // Full normal transfer: launch, one WAIT cycle, reply, DONE, back to IDLE.
   task automatic do_txn(input string tag, input logic [7:0] rx_byte, output int gidx);
      logic [7:0] exp_tx;
      wait_launch(tag);
      gidx = -1;
      for (int i = 0; i < NR; i++) if (gnt[i]) gidx = i;
      check({tag, "_gnt_onehot"}, 32'($countones(gnt)), 1);
      exp_tx = (gidx >= 0) ? req_data[gidx*DW +: DW] : 8'h00;
      check({tag, "_tx"}, 32'(spi_send_data), 32'(exp_tx));
      step();
      check({tag, "_en_pulse"}, 32'(spi_send_en), 0);
      spi_rx_data  = rx_byte;
      spi_rx_valid = 1'b1;
      step();
      check({tag, "_rsp_valid"}, 32'(rsp_valid), (gidx >= 0) ? 32'(1) << gidx : 32'hFFFF);
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'(rx_byte));
      check({tag, "_rsp_err"}, 32'(rsp_err), 0);
      spi_rx_valid = 1'b0;
      step();
      check({tag, "_rsp_clear"}, 32'(rsp_valid), 0);
   endtask

   initial begin
      int g;
      int order[5];
      int cycles;
      int exp_order[5] = '{0, 1, 2, 3, 0};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_rsp_err", 32'(rsp_err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_send_en", 32'(spi_send_en), 0);
      check("rst_send_data", 32'(spi_send_data), 0);
      rst = 1'b1;
      step();

      // all requesting, rr_ptr starts at 0
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         do_txn("rr", 8'h80 + 8'(t), g);
         order[t] = g;
         if (t == 4) req = '0;
      end
      for (int t = 0; t < 5; t++) check("rr_order", 32'(order[t]), 32'(exp_order[t]));
      step();

      // single request on requester 2
      req_data[23:16] = 8'hA5;
      req = 4'b0100;
      step();
      check("t1_launch_en", 32'(spi_send_en), 1);
      check("t1_launch_gnt", 32'(gnt), 32'b0100);
      check("t1_launch_data", 32'(spi_send_data), 32'hA5);
      check("t1_launch_busy", 32'(busy), 1);
      step();
      check("t1_wait_en", 32'(spi_send_en), 0);
      check("t1_wait_gnt", 32'(gnt), 32'b0100);
      check("t1_wait_data", 32'(spi_send_data), 32'hA5);
      spi_rx_data  = 8'h3C;
      spi_rx_valid = 1'b1;
      step();
      check("t1_done_valid", 32'(rsp_valid), 32'b0100);
      check("t1_done_data", 32'(rsp_data), 32'h3C);
      check("t1_done_err", 32'(rsp_err), 0);
      check("t1_done_gnt", 32'(gnt), 32'b0100);
      spi_rx_valid = 1'b0;
      req = '0;
      step();
      check("t1_idle_valid", 32'(rsp_valid), 0);
      check("t1_idle_gnt", 32'(gnt), 0);
      check("t1_idle_busy", 32'(busy), 0);
      check("t1_idle_hold", 32'(rsp_data), 32'h3C);

      // timeout on requester 1
      req_data[15:8] = 8'h77;
      req = 4'b0010;
      wait_launch("t3");
      check("t3_gnt", 32'(gnt), 32'b0010);
      step();
      cycles = 0;
      while (rsp_valid == '0 && cycles < TO + 4) begin
         step();
         cycles++;
      end
      check("t3_latency", 32'(cycles), 32'(TO));
      check("t3_valid", 32'(rsp_valid), 32'b0010);
      check("t3_err", 32'(rsp_err), 1);
      check("t3_data", 32'(rsp_data), 0);
      req = '0;
      step();

      // reply on the terminal timer cycle beats the abort
      req_data[7:0] = 8'h5A;
      req = 4'b0001;
      wait_launch("t4");
      check("t4_tx", 32'(spi_send_data), 32'h5A);
      step();
      repeat (TO - 1) @(posedge clk);
      #1;
      check("t4_pre_valid", 32'(rsp_valid), 0);
      check("t4_pre_busy", 32'(busy), 1);
      spi_rx_data  = 8'hC3;
      spi_rx_valid = 1'b1;
      step();
      check("t4_valid", 32'(rsp_valid), 32'b0001);
      check("t4_err", 32'(rsp_err), 0);
      check("t4_data", 32'(rsp_data), 32'hC3);
      spi_rx_valid = 1'b0;
      req = '0;
      step();

      // req drop mid-transfer, then stray reply in IDLE
      req_data[31:24] = 8'h99;
      req = 4'b1000;
      wait_launch("t5");
      step();
      req = '0;
      req_data[31:24] = 8'h11;
      step();
      step();
      check("t5_tx_hold", 32'(spi_send_data), 32'h99);
      check("t5_busy", 32'(busy), 1);
      spi_rx_data  = 8'h42;
      spi_rx_valid = 1'b1;
      step();
      check("t5_valid", 32'(rsp_valid), 32'b1000);
      check("t5_data", 32'(rsp_data), 32'h42);
      spi_rx_valid = 1'b0;
      step();
      check("t5_gnt_clear", 32'(gnt), 0);
      spi_rx_data  = 8'hEE;
      spi_rx_valid = 1'b1;
      step();
      check("t5_stray_valid", 32'(rsp_valid), 0);
      check("t5_stray_busy", 32'(busy), 0);
      step();
      check("t5_stray_data", 32'(rsp_data), 32'h42);
      spi_rx_valid = 1'b0;

      // advance rr_ptr to 2, then reset during WAIT
      req_data[15:8] = 8'h21;
      req = 4'b0010;
      do_txn("pre6", 8'h21, g);
      check("pre6_idx", 32'(g), 1);
      req = '0;
      step();
      req_data[23:16] = 8'h33;
      req = 4'b0100;
      wait_launch("t6");
      step();
      step();
      rst = 1'b0;
      #1;
      check("t6_gnt", 32'(gnt), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_send_en", 32'(spi_send_en), 0);
      check("t6_send_data", 32'(spi_send_data), 0);
      check("t6_rsp_valid", 32'(rsp_valid), 0);
      check("t6_rsp_data", 32'(rsp_data), 0);
      check("t6_rsp_err", 32'(rsp_err), 0);
      req = '0;
      step();
      step();
      rst = 1'b1;
      step();
      step();
      check("t6_no_stale", 32'(rsp_valid), 0);
      check("t6_idle", 32'(busy), 0);
      req_data[15:8]  = 8'h61;
      req_data[31:24] = 8'h63;
      req = 4'b1010;
      do_txn("post6", 8'h5E, g);
      check("post6_rr_ptr", 32'(g), 1);
      req = '0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
